alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_pkg.sv | 61 ++++++
 rtl/alu_ctrl_decode.sv | 35 +++
 rtl/alu_ctrl_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control sequencer: state encoding,
// opcode map, ALU operation codes and instruction-field placement helpers.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  localparam int OPC_W   = 5;
  localparam int ALUOP_W = 4;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'd5;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'd6;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'd7;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'd8;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'd9;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'd10;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_SHR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SHRA = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_ROR  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SHL  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_ROL  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_MUL  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_DIV  = 4'd10;

  // Opcode sits in the top OPC_W bits; Ra, Rb, Rc follow downwards.
  function automatic int opc_lsb(input int data_w);
    return data_w - OPC_W;
  endfunction

  function automatic int ra_lsb(input int data_w, input int idx_w);
    return data_w - OPC_W - idx_w;
  endfunction

  function automatic int rb_lsb(input int data_w, input int idx_w);
    return data_w - OPC_W - (2 * idx_w);
  endfunction

  function automatic int rc_lsb(input int data_w, input int idx_w);
    return data_w - OPC_W - (3 * idx_w);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: ALU operation, MUL/DIV class and illegal flag.
// MUL/DIV are only legal when ALU_CTRL_MULDIV_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_muldiv,
  output logic               is_illegal
);

  // Opcode classification; anything not listed is illegal.
  always_comb begin
    alu_op     = ALU_ADD;
    is_muldiv  = 1'b0;
    is_illegal = 1'b1;
    case (opcode)
      OPC_ADD:  begin alu_op = ALU_ADD;  is_illegal = 1'b0; end
      OPC_SUB:  begin alu_op = ALU_SUB;  is_illegal = 1'b0; end
      OPC_AND:  begin alu_op = ALU_AND;  is_illegal = 1'b0; end
      OPC_OR:   begin alu_op = ALU_OR;   is_illegal = 1'b0; end
      OPC_SHR:  begin alu_op = ALU_SHR;  is_illegal = 1'b0; end
      OPC_SHRA: begin alu_op = ALU_SHRA; is_illegal = 1'b0; end
      OPC_ROR:  begin alu_op = ALU_ROR;  is_illegal = 1'b0; end
      OPC_SHL:  begin alu_op = ALU_SHL;  is_illegal = 1'b0; end
      OPC_ROL:  begin alu_op = ALU_ROL;  is_illegal = 1'b0; end
`ifdef ALU_CTRL_MULDIV_EN
      OPC_MUL:  begin alu_op = ALU_MUL;  is_muldiv = 1'b1; is_illegal = 1'b0; end
      OPC_DIV:  begin alu_op = ALU_DIV;  is_muldiv = 1'b1; is_illegal = 1'b0; end
`endif
      default:  begin alu_op = ALU_ADD;  is_muldiv = 1'b0; is_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Hardwired control sequencer for a single-bus ALU datapath; strobes are Moore
// outputs of the registered state and ir. Define ALU_CTRL_MULDIV_EN for MUL/DIV.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  ir,
  input  logic               mem_ready,
  output logic [NREG-1:0]    Rin,
  output logic [NREG-1:0]    Rout,
  output logic               PCin,
  output logic               PCout,
  output logic               IncPC,
  output logic               MARin,
  output logic               Read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               Zlowin,
  output logic               Zhighin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               HIin,
  output logic               LOin,
  output logic [3:0]         ALUop,
  output logic               busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam int REG_IDX_W = $clog2(NREG);
  localparam int OPC_LSB   = opc_lsb(DATA_W);
  localparam int RA_LSB    = ra_lsb(DATA_W, REG_IDX_W);
  localparam int RB_LSB    = rb_lsb(DATA_W, REG_IDX_W);
  localparam int RC_LSB    = rc_lsb(DATA_W, REG_IDX_W);

  state_e                 state_r;
  state_e                 state_next_s;
  logic                   t1_first_r;
  logic                   illegal_r;
  logic [CNT_W-1:0]       retired_r;
  logic [OPC_W-1:0]       opcode_s;
  logic [REG_IDX_W-1:0]   ra_s;
  logic [REG_IDX_W-1:0]   rb_s;
  logic [REG_IDX_W-1:0]   rc_s;
  logic [ALUOP_W-1:0]     alu_op_s;
  logic                   is_muldiv_s;
  logic                   is_illegal_s;
  logic                   eoi_s;
  logic [NREG-1:0]        one_s;
  logic                   unused_ir_s;

  assign opcode_s    = ir[OPC_LSB +: OPC_W];
  assign ra_s        = ir[RA_LSB +: REG_IDX_W];
  assign rb_s        = ir[RB_LSB +: REG_IDX_W];
  assign rc_s        = ir[RC_LSB +: REG_IDX_W];
  assign unused_ir_s = ^ir[RC_LSB-1:0];
  assign one_s       = {{(NREG-1){1'b0}}, 1'b1};

  alu_ctrl_decode u_decode (
    .opcode     (opcode_s),
    .alu_op     (alu_op_s),
    .is_muldiv  (is_muldiv_s),
    .is_illegal (is_illegal_s)
  );

  // Last step of an instruction: T5 for single-result ops, T6 for MUL/DIV.
  assign eoi_s   = ((state_r == ST_T5) && !is_muldiv_s) || (state_r == ST_T6);
  assign busy    = (state_r != ST_IDLE) && (state_r != ST_HALT);
  assign illegal = illegal_r;
  assign retired = retired_r;

  // State register, first-T1 marker, sticky illegal flag and retire counter.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r    <= ST_IDLE;
      t1_first_r <= 1'b0;
      illegal_r  <= 1'b0;
      retired_r  <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      t1_first_r <= (state_r == ST_T0);
      if ((state_r == ST_T3) && is_illegal_s) begin
        illegal_r <= 1'b1;
      end
      if (eoi_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; HALT is absorbing until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_T0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_T0: state_next_s = ST_T1;
      ST_T1: begin
        if (mem_ready) begin
          state_next_s = ST_T2;
        end else begin
          state_next_s = ST_T1;
        end
      end
      ST_T2: state_next_s = ST_T3;
      ST_T3: begin
        if (is_illegal_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_T4;
        end
      end
      ST_T4: state_next_s = ST_T5;
      ST_T5: begin
`ifdef ALU_CTRL_MULDIV_EN
        if (is_muldiv_s) begin
          state_next_s = ST_T6;
        end else if (start) begin
          state_next_s = ST_T0;
        end else begin
          state_next_s = ST_IDLE;
        end
`else
        if (start) begin
          state_next_s = ST_T0;
        end else begin
          state_next_s = ST_IDLE;
        end
`endif
      end
`ifdef ALU_CTRL_MULDIV_EN
      ST_T6: begin
        if (start) begin
          state_next_s = ST_T0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
`endif
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath strobes per state; anything not set here stays low.
  always_comb begin
    Rin      = {NREG{1'b0}};
    Rout     = {NREG{1'b0}};
    PCin     = 1'b0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ALUop    = 4'd0;
    case (state_r)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = t1_first_r;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (!is_illegal_s) begin
          Rout = one_s << rb_s;
          Yin  = 1'b1;
        end else begin
          Yin  = 1'b0;
        end
      end
      ST_T4: begin
        Rout   = one_s << rc_s;
        ALUop  = alu_op_s;
        Zlowin = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
        Zhighin = is_muldiv_s;
`endif
      end
      ST_T5: begin
        Zlowout = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
        if (is_muldiv_s) begin
          LOin = 1'b1;
        end else begin
          Rin  = one_s << ra_s;
        end
`else
        Rin = one_s << ra_s;
`endif
      end
`ifdef ALU_CTRL_MULDIV_EN
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      default: begin
        Yin = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: per-cycle expected strobe vectors are
// queued when an instruction is issued and popped as the sequencer steps.
module tb_alu_ctrl_seq;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;

  logic [15:0] rin, rout;
  logic pcin, pcout, incpc, marin, read, mdrin, mdrout, irin, yin;
  logic zlowin, zhighin, zlowout, zhighout, hiin, loin, busy, illegal;
  logic [3:0]  aluop;
  logic [15:0] retired;

  logic [15:0] b_rin, b_rout;
  logic b_pcin, b_pcout, b_incpc, b_marin, b_read, b_mdrin, b_mdrout, b_irin, b_yin;
  logic b_zlowin, b_zhighin, b_zlowout, b_zhighout, b_hiin, b_loin, b_busy, b_illegal;
  logic [3:0]  b_aluop;
  logic [1:0]  b_retired;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, incpc, marin, read, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
    logic [3:0] aluop;
    logic busy;
    logic illegal;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_ret = 0;

  always #5 clock = ~clock;

  alu_ctrl_seq dut (
    .clock(clock), .clear_n(clear_n), .start(start), .ir(ir), .mem_ready(mem_ready),
    .Rin(rin), .Rout(rout), .PCin(pcin), .PCout(pcout), .IncPC(incpc), .MARin(marin),
    .Read(read), .MDRin(mdrin), .MDRout(mdrout), .IRin(irin), .Yin(yin),
    .Zlowin(zlowin), .Zhighin(zhighin), .Zlowout(zlowout), .Zhighout(zhighout),
    .HIin(hiin), .LOin(loin), .ALUop(aluop), .busy(busy), .illegal(illegal),
    .retired(retired)
  );

  alu_ctrl_seq #(.CNT_W(2)) dut_small (
    .clock(clock), .clear_n(clear_n), .start(start), .ir(ir), .mem_ready(mem_ready),
    .Rin(b_rin), .Rout(b_rout), .PCin(b_pcin), .PCout(b_pcout), .IncPC(b_incpc),
    .MARin(b_marin), .Read(b_read), .MDRin(b_mdrin), .MDRout(b_mdrout), .IRin(b_irin),
    .Yin(b_yin), .Zlowin(b_zlowin), .Zhighin(b_zhighin), .Zlowout(b_zlowout),
    .Zhighout(b_zhighout), .HIin(b_hiin), .LOin(b_loin), .ALUop(b_aluop),
    .busy(b_busy), .illegal(b_illegal), .retired(b_retired)
  );

  function automatic obs_t cap();
    obs_t o;
    o = '{rin, rout, pcin, pcout, incpc, marin, read, mdrin, mdrout, irin, yin,
          zlowin, zhighin, zlowout, zhighout, hiin, loin, aluop, busy, illegal};
    return o;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] o, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {o, a, b, c, 15'd0};
  endfunction

  // Reference behaviour of one instruction, one entry per clock cycle.
  task automatic push_exp(input logic [31:0] i, input int stalls, input int halt_cycles);
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic [15:0] one;
    bit          md, legal;
    obs_t        e;
    opc = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
    one = 16'd1;
`ifdef ALU_CTRL_MULDIV_EN
    md = (opc == 5'd9) || (opc == 5'd10);
`else
    md = 1'b0;
`endif
    legal = (opc <= 5'd8) || md;
    e = '0; e.busy = 1'b1; e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zlowin = 1'b1;
    sb.push_back(e);
    for (int s = 0; s <= stalls; s++) begin
      e = '0; e.busy = 1'b1; e.zlowout = 1'b1; e.read = 1'b1; e.mdrin = 1'b1;
      e.pcin = (s == 0);
      sb.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.mdrout = 1'b1; e.irin = 1'b1;
    sb.push_back(e);
    if (!legal) begin
      e = '0; e.busy = 1'b1;
      sb.push_back(e);
      for (int h = 0; h < halt_cycles; h++) begin
        e = '0; e.illegal = 1'b1;
        sb.push_back(e);
      end
    end else begin
      e = '0; e.busy = 1'b1; e.rout = one << rb; e.yin = 1'b1;
      sb.push_back(e);
      e = '0; e.busy = 1'b1; e.rout = one << rc; e.aluop = opc[3:0]; e.zlowin = 1'b1;
      e.zhighin = md;
      sb.push_back(e);
      e = '0; e.busy = 1'b1; e.zlowout = 1'b1;
      if (md) e.loin = 1'b1;
      else    e.rin  = one << ra;
      sb.push_back(e);
      if (md) begin
        e = '0; e.busy = 1'b1; e.zhighout = 1'b1; e.hiin = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_sb(input string tag, input int stalls, input bit keep, input bit pulse);
    int   n;
    obs_t got, want;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      if (!keep) start = pulse ? (k % 2 == 1) : 1'b0;
      mem_ready = !((k >= 1) && (k <= stalls));
      @(negedge clock);
      got  = cap();
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, got, want);
      end
    end
    start = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [31:0] i, input int stalls, input bit keep);
    ir = i; start = 1'b1; mem_ready = (stalls == 0);
    push_exp(i, stalls, 0);
    run_sb(tag, stalls, keep, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    @(posedge clock); @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || retired !== 16'(exp_ret)) begin
      n_fail++;
      $display("FAIL %s idle: busy %b retired %0d expected busy 0 retired %0d",
               tag, busy, retired, exp_ret);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; mem_ready = 1'b1; ir = 32'd0;
    @(negedge clock); clear_n = 1'b0;
    @(negedge clock); clear_n = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; mem_ready = 1'b1; ir = 32'd0;
    #2;
    n_tests++;
    if (cap() !== obs_t'('0) || retired !== 16'd0 || b_retired !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: got %h retired %0d expected all zero", cap(), retired);
    end
    @(negedge clock); @(negedge clock); clear_n = 1'b1;
    @(negedge clock);
    n_tests++;
    if (cap() !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected 0", cap());
    end
  endtask

  task automatic test_shl();
    exec("shl", 32'h3B820000, 0, 1'b0);
    exp_ret++;
    check_idle("shl");
  endtask

  task automatic test_stall();
    exec("stall", mk(5'd1, 4'd1, 4'd2, 4'd3), 3, 1'b0);
    exp_ret++;
    check_idle("stall");
  endtask

  task automatic test_ops();
    for (int o = 0; o <= 8; o++) begin
      exec("ops", mk(5'(o), 4'(o + 3), 4'(o * 5), 4'(15 - o)), o % 3, 1'b0);
      exp_ret++;
      check_idle("ops");
    end
    exec("same_reg", mk(5'd0, 4'd9, 4'd9, 4'd9), 0, 1'b0);
    exp_ret++;
    check_idle("same_reg");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      exec("b2b", mk(5'd0, 4'(j), 4'(j + 1), 4'(j + 2)), 0, (j < 4));
      exp_ret++;
    end
    check_idle("b2b");
    n_tests++;
    if (b_retired !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_wrap: retired %0d expected 1", b_retired);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir = mk(5'd2, 4'd1, 4'd1, 4'd1); start = 1'b1; mem_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    n_tests++;
    if (zlowin !== 1'b1 || aluop !== 4'd2) begin
      n_fail++;
      $display("FAIL mid_t4: zlowin %b aluop %0d expected 1 and 2", zlowin, aluop);
    end
    clear_n = 1'b0;
    #1;
    n_tests++;
    if (cap() !== obs_t'('0) || retired !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h retired %0d expected 0", cap(), retired);
    end
    @(negedge clock); clear_n = 1'b1;
  endtask

  task automatic test_muldiv();
`ifdef ALU_CTRL_MULDIV_EN
    exec("mul", 32'h48118000, 0, 1'b0);
    exp_ret++;
    check_idle("mul");
    exec("div", mk(5'd10, 4'd5, 4'd6, 4'd7), 1, 1'b0);
    exp_ret++;
    check_idle("div");
`else
    ir = 32'h48118000; start = 1'b1; mem_ready = 1'b1;
    push_exp(32'h48118000, 0, 3);
    run_sb("mul_off", 0, 1'b0, 1'b0);
    n_tests++;
    if (illegal !== 1'b1 || retired !== 16'(exp_ret)) begin
      n_fail++;
      $display("FAIL mul_off_halt: illegal %b retired %0d expected 1 and %0d",
               illegal, retired, exp_ret);
    end
    do_reset();
`endif
  endtask

  task automatic test_illegal();
    ir = 32'hF8000000; start = 1'b1; mem_ready = 1'b1;
    push_exp(32'hF8000000, 0, 5);
    run_sb("illegal", 0, 1'b0, 1'b1);
    n_tests++;
    if (retired !== 16'(exp_ret)) begin
      n_fail++;
      $display("FAIL illegal_ret: retired %0d expected %0d", retired, exp_ret);
    end
    do_reset();
    @(negedge clock);
    n_tests++;
    if (illegal !== 1'b0 || busy !== 1'b0 || retired !== 16'd0) begin
      n_fail++;
      $display("FAIL illegal_clear: illegal %b busy %b retired %0d expected 0",
               illegal, busy, retired);
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_stall();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    test_muldiv();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
